piso_tx_sched: RTL and testbench

//  Sequencer/arbiter that shares one parallel-in serial-out shifter between NUM_REQ requesters.

---
 rtl/piso_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/piso_tx_sched.sv | 105 ++++++++++
 tb/tb_piso_tx_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the serial transmit scheduler: FSM encoding and default word size.
package piso_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage : piso_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after last_grant (wrapping).
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IW      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx
);

    logic        w_found;
    int unsigned w_cand;

    // Scan requesters starting one past the previous winner; first valid one wins.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_cand = (32'(last_grant) + 32'd1 + i) % NUM_REQ;
            if (en && !w_found && req[IW'(w_cand)]) begin
                w_found          = 1'b1;
                gnt[IW'(w_cand)] = 1'b1;
                idx              = IW'(w_cand);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/piso_tx_sched.sv
// Shares one parallel-in serial-out shifter between several word producers, MSB first with framing.
module piso_tx_sched
    import piso_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [NUM_REQ-1:0]                               req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]                    req_data,
    output logic [NUM_REQ-1:0]                               req_ready,
    output logic                                             s_out,
    output logic                                             s_valid,
    output logic                                             s_first,
    output logic                                             s_last,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                                             busy
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [CW-1:0]         r_bitcnt;
    logic [GW-1:0]         r_gapcnt;
    logic [IW-1:0]         r_last_grant;
    logic [IW-1:0]         r_grant_id;

    logic [NUM_REQ-1:0]    w_gnt;
    logic [IW-1:0]         w_idx;
    logic                  w_arb_en;

    // Arbitration only while idle and out of reset, so no accept can leak during reset.
    assign w_arb_en = (r_state == ST_IDLE) && !rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .en         (w_arb_en),
        .gnt        (w_gnt),
        .idx        (w_idx)
    );

    // Sequencer: load the granted word, shift it out, then hold the line idle for the gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_bitcnt     <= '0;
            r_gapcnt     <= '0;
            r_last_grant <= IW'(NUM_REQ - 1);
            r_grant_id   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_shreg      <= req_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
                        r_bitcnt     <= CW'(DATA_WIDTH - 1);
                        r_last_grant <= w_idx;
                        r_grant_id   <= w_idx;
                        r_state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_shreg  <= r_shreg << 1;
                    r_bitcnt <= r_bitcnt - CW'(1);
                    if (r_bitcnt == '0) begin
                        if (GAP_CYCLES > 0) begin
                            r_gapcnt <= GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
                            r_state  <= ST_GAP;
                        end else begin
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    r_gapcnt <= r_gapcnt - GW'(1);
                    if (r_gapcnt == '0) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Line outputs decode straight from registered state; data bit forced low off-frame.
    assign s_valid   = (r_state == ST_SHIFT);
    assign s_out     = s_valid && r_shreg[DATA_WIDTH-1];
    assign s_first   = s_valid && (r_bitcnt == CW'(DATA_WIDTH - 1));
    assign s_last    = s_valid && (r_bitcnt == '0);
    assign busy      = (r_state != ST_IDLE);
    assign grant_id  = r_grant_id;
    assign req_ready = w_gnt;

endmodule : piso_tx_sched

// File: tb/tb_piso_tx_sched.sv
// Directed bench: a 4-bit/2-requester/1-gap instance and a 1-bit/1-requester/no-gap instance.
module tb_piso_tx_sched;

    logic clk;
    int   n_cmp = 0;
    int   n_err = 0;

    // Instance A: DATA_WIDTH=4, NUM_REQ=2, GAP_CYCLES=1
    logic       rst_a;
    logic [1:0] req_valid_a;
    logic [7:0] req_data_a;
    logic [1:0] req_ready_a;
    logic       s_out_a, s_valid_a, s_first_a, s_last_a, busy_a;
    logic [0:0] grant_id_a;

    // Instance B: DATA_WIDTH=1, NUM_REQ=1, GAP_CYCLES=0
    logic       rst_b;
    logic [0:0] req_valid_b;
    logic [0:0] req_data_b;
    logic [0:0] req_ready_b;
    logic       s_out_b, s_valid_b, s_first_b, s_last_b, busy_b;
    logic [0:0] grant_id_b;

    piso_tx_sched #(.DATA_WIDTH(4), .NUM_REQ(2), .GAP_CYCLES(1)) u_dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .req_valid (req_valid_a),
        .req_data  (req_data_a),
        .req_ready (req_ready_a),
        .s_out     (s_out_a),
        .s_valid   (s_valid_a),
        .s_first   (s_first_a),
        .s_last    (s_last_a),
        .grant_id  (grant_id_a),
        .busy      (busy_a)
    );

    piso_tx_sched #(.DATA_WIDTH(1), .NUM_REQ(1), .GAP_CYCLES(0)) u_dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .req_valid (req_valid_b),
        .req_data  (req_data_b),
        .req_ready (req_ready_b),
        .s_out     (s_out_b),
        .s_valid   (s_valid_b),
        .s_first   (s_first_b),
        .s_last    (s_last_b),
        .grant_id  (grant_id_b),
        .busy      (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_a();
        @(negedge clk);
        rst_a       = 1'b1;
        req_valid_a = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    // Follows one 4-bit word from its first shift cycle through the gap cycle.
    task automatic word_a(input string tag, input logic [3:0] d, input logic [0:0] gid, input bit keep);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0 && !keep) req_valid_a = 2'b00;
            #1;
            check({tag, "_svalid"}, 32'(s_valid_a), 32'd1);
            check({tag, "_sout"},   32'(s_out_a),   32'(d[3-i]));
            check({tag, "_first"},  32'(s_first_a), 32'(i == 0));
            check({tag, "_last"},   32'(s_last_a),  32'(i == 3));
            check({tag, "_gid"},    32'(grant_id_a), 32'(gid));
            check({tag, "_ready"},  32'(req_ready_a), 32'd0);
        end
        @(negedge clk);
        #1;
        check({tag, "_gap_svalid"}, 32'(s_valid_a), 32'd0);
        check({tag, "_gap_sout"},   32'(s_out_a),   32'd0);
        check({tag, "_gap_busy"},   32'(busy_a),    32'd1);
    endtask

    initial begin
        logic [3:0] pat;

        rst_a       = 1'b1;
        req_valid_a = 2'b11;
        req_data_a  = 8'hFF;
        rst_b       = 1'b1;
        req_valid_b = 1'b1;
        req_data_b  = 1'b1;

        // Reset state, with requests pending that must not be accepted
        @(negedge clk);
        #1;
        check("rst_ready",  32'(req_ready_a), 32'd0);
        check("rst_svalid", 32'(s_valid_a),   32'd0);
        check("rst_sout",   32'(s_out_a),     32'd0);
        check("rst_first",  32'(s_first_a),   32'd0);
        check("rst_last",   32'(s_last_a),    32'd0);
        check("rst_busy",   32'(busy_a),      32'd0);
        check("rst_gid",    32'(grant_id_a),  32'd0);
        check("rst_b_ready", 32'(req_ready_b), 32'd0);
        req_valid_a = 2'b00;
        @(negedge clk);
        rst_a = 1'b0;

        // 1: single word 1011 from requester 0
        @(negedge clk);
        req_valid_a = 2'b01;
        req_data_a  = {4'h0, 4'b1011};
        #1;
        check("t1_ready", 32'(req_ready_a), 32'd1);
        check("t1_busy0", 32'(busy_a), 32'd0);
        word_a("t1", 4'b1011, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("t1_idle_busy",  32'(busy_a),      32'd0);
        check("t1_idle_ready", 32'(req_ready_a), 32'd0);

        // 2: round robin with both continuously valid
        reset_a();
        req_valid_a = 2'b11;
        req_data_a  = {4'h5, 4'hA};
        for (int w = 0; w < 4; w++) begin
            if (w != 0) @(negedge clk);
            #1;
            check("t2_ready", 32'(req_ready_a), (w % 2 == 0) ? 32'd1 : 32'd2);
            check("t2_busy",  32'(busy_a), 32'd0);
            word_a("t2", (w % 2 == 0) ? 4'hA : 4'h5, 1'((w % 2)), 1'b1);
        end
        req_valid_a = 2'b00;

        // 3: reset mid-word
        reset_a();
        @(negedge clk);
        req_valid_a = 2'b01;
        req_data_a  = {4'h0, 4'hF};
        #1;
        check("t3_ready", 32'(req_ready_a), 32'd1);
        @(negedge clk);
        req_valid_a = 2'b00;
        #1;
        check("t3_bit1", 32'(s_out_a), 32'd1);
        @(negedge clk);
        #1;
        check("t3_bit2",    32'(s_out_a),   32'd1);
        check("t3_bit2_sv", 32'(s_valid_a), 32'd1);
        #1;
        rst_a       = 1'b1;
        req_valid_a = 2'b11;
        #1;
        check("t3_rst_svalid", 32'(s_valid_a),   32'd0);
        check("t3_rst_sout",   32'(s_out_a),     32'd0);
        check("t3_rst_busy",   32'(busy_a),      32'd0);
        check("t3_rst_ready",  32'(req_ready_a), 32'd0);
        @(negedge clk);
        rst_a       = 1'b0;
        req_valid_a = 2'b00;
        @(negedge clk);
        req_valid_a = 2'b11;
        req_data_a  = {4'h5, 4'h9};
        #1;
        check("t3_after_ready", 32'(req_ready_a), 32'd1);

        // 4: requester 1 pulses valid during the shift and withdraws
        @(negedge clk);
        req_valid_a = 2'b10;
        #1;
        check("t4_s1_sout",  32'(s_out_a),     32'd1);
        check("t4_s1_gid",   32'(grant_id_a),  32'd0);
        check("t4_s1_ready", 32'(req_ready_a), 32'd0);
        @(negedge clk);
        req_valid_a = 2'b00;
        #1;
        check("t4_s2_sout", 32'(s_out_a), 32'd0);
        @(negedge clk);
        #1;
        check("t4_s3_sout", 32'(s_out_a), 32'd0);
        @(negedge clk);
        #1;
        check("t4_s4_sout", 32'(s_out_a),  32'd1);
        check("t4_s4_last", 32'(s_last_a), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check("t4_ready",  32'(req_ready_a), 32'd0);
            check("t4_svalid", 32'(s_valid_a),   32'd0);
            check("t4_gid",    32'(grant_id_a),  32'd0);
            if (c > 0) check("t4_busy", 32'(busy_a), 32'd0);
        end

        // 6: idle line
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            check("t6_svalid", 32'(s_valid_a),   32'd0);
            check("t6_sout",   32'(s_out_a),     32'd0);
            check("t6_ready",  32'(req_ready_a), 32'd0);
        end

        // 5: one-bit words, no gap, single requester
        @(negedge clk);
        rst_b       = 1'b0;
        req_valid_b = 1'b0;
        pat = 4'b1011;
        @(negedge clk);
        req_valid_b = 1'b1;
        req_data_b  = pat[3];
        #1;
        check("t5_ready0", 32'(req_ready_b), 32'd1);
        check("t5_busy0",  32'(busy_b),      32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("t5_svalid", 32'(s_valid_b),   32'd1);
            check("t5_sout",   32'(s_out_b),     32'(pat[3-k]));
            check("t5_first",  32'(s_first_b),   32'd1);
            check("t5_last",   32'(s_last_b),    32'd1);
            check("t5_busy",   32'(busy_b),      32'd1);
            check("t5_sready", 32'(req_ready_b), 32'd0);
            if (k < 3) req_data_b = pat[2-k];
            else       req_valid_b = 1'b0;
            @(negedge clk);
            #1;
            check("t5_idle_svalid", 32'(s_valid_b),   32'd0);
            check("t5_idle_sout",   32'(s_out_b),     32'd0);
            check("t5_idle_ready",  32'(req_ready_b), (k < 3) ? 32'd1 : 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_piso_tx_sched
